// File: rtl/cross_bar_pkg.sv
// +----------------------------------------------------------------------------+
// | cross_bar_pkg : shared crossbar constants and arbiter types                 |
// | rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

package cross_bar_pkg;

  localparam int MASTER_N  = 4;
  localparam int SLAVE_N   = 4;
  localparam int MASTER_W  = $clog2(MASTER_N);
  localparam int MAX_BURST = 4;
  localparam int BURST_W   = $clog2(MAX_BURST + 1);

  typedef logic [SLAVE_N-1:0] sgrant_t;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/xbar_prio_pick.sv
// +----------------------------------------------------------------------------+
// | xbar_prio_pick : combinational winner select, round-robin or fixed priority |
// | rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module xbar_prio_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  input  logic         fixed_i,
  output logic [W-1:0] idx_o,
  output logic         vld_o
);

  // Scan from the farthest candidate down so the closest one is written last.
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = fixed_i ? k : int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (req_i[j]) begin
        idx_o = W'(j);
        vld_o = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/xbar_arbiter.sv
// +----------------------------------------------------------------------------+
// | xbar_arbiter : per-slave arbiter with burst lock and zero-bubble handover   |
// | rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module xbar_arbiter #(
  parameter  int MASTER_N  = cross_bar_pkg::MASTER_N,
  parameter  int MAX_BURST = cross_bar_pkg::MAX_BURST,
  localparam int MASTER_W  = $clog2(MASTER_N),
  localparam int BURST_W   = $clog2(MAX_BURST + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [MASTER_N-1:0] req_i,
  input  logic [MASTER_N-1:0] lock_i,
  input  logic                fixed_prio_i,
  input  logic                ack_i,
  output logic [MASTER_N-1:0] grant_o,
  output logic [MASTER_W-1:0] grant_idx_o,
  output logic                grant_vld_o,
  output logic [BURST_W-1:0]  burst_cnt_o
);

  import cross_bar_pkg::*;

  arb_state_t          state_q, state_d;
  logic [MASTER_N-1:0] grant_q, grant_d;
  logic [MASTER_W-1:0] idx_q, idx_d;
  logic [MASTER_W-1:0] ptr_q, ptr_d;
  logic                vld_q, vld_d;
  logic [BURST_W-1:0]  cnt_q, cnt_d;

  logic [MASTER_N-1:0] pick_req;
  logic [MASTER_W-1:0] pick_ptr, pick_idx, next_ptr;
  logic                pick_vld;
  logic                own_req, own_lock, at_limit, limit_rel, release_grant;

  assign own_req   = req_i[idx_q];
  assign own_lock  = lock_i[idx_q];
  assign at_limit  = (cnt_q >= BURST_W'(MAX_BURST - 1));
  assign limit_rel = ack_i && at_limit;
  assign release_grant = !own_req || (ack_i && (!own_lock || at_limit));
  assign next_ptr  = (idx_q == MASTER_W'(MASTER_N - 1)) ? '0 : idx_q + 1'b1;

  // Handover arbitrates from the post-release pointer; only a burst that ran
  // out its limit is kept from immediately winning again.
  assign pick_req = (state_q == OWNED && limit_rel) ? (req_i & ~grant_q) : req_i;
  assign pick_ptr = (state_q == OWNED) ? next_ptr : ptr_q;

  xbar_prio_pick #(
    .N (MASTER_N),
    .W (MASTER_W)
  ) u_pick (
    .req_i   (pick_req),
    .ptr_i   (pick_ptr),
    .fixed_i (fixed_prio_i),
    .idx_o   (pick_idx),
    .vld_o   (pick_vld)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    vld_d   = vld_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pick_vld) begin
          state_d = OWNED;
          idx_d   = pick_idx;
          grant_d = MASTER_N'(1) << pick_idx;
          vld_d   = 1'b1;
        end
      end
      OWNED: begin
        if (release_grant) begin
          ptr_d = next_ptr;
          cnt_d = '0;
          if (pick_vld) begin
            idx_d   = pick_idx;
            grant_d = MASTER_N'(1) << pick_idx;
            vld_d   = 1'b1;
          end else begin
            state_d = IDLE;
            idx_d   = '0;
            grant_d = '0;
            vld_d   = 1'b0;
          end
        end else if (ack_i && (cnt_q < BURST_W'(MAX_BURST))) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_o     = grant_q;
  assign grant_idx_o = idx_q;
  assign grant_vld_o = vld_q;
  assign burst_cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_xbar_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_xbar_arbiter : directed bench with a reference arbitration model         |
// | rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_xbar_arbiter;

  localparam int N  = 4;
  localparam int MB = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req_i = '0;
  logic [N-1:0] lock_i = '0;
  logic         fixed_prio_i = 1'b0;
  logic         ack_i = 1'b0;
  logic [N-1:0] grant_o;
  logic [1:0]   grant_idx_o;
  logic         grant_vld_o;
  logic [2:0]   burst_cnt_o;

  int errors = 0;
  int checks = 0;

  int m_owner = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;

  always #5 clk = ~clk;

  xbar_arbiter #(
    .MASTER_N  (N),
    .MAX_BURST (MB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req_i),
    .lock_i       (lock_i),
    .fixed_prio_i (fixed_prio_i),
    .ack_i        (ack_i),
    .grant_o      (grant_o),
    .grant_idx_o  (grant_idx_o),
    .grant_vld_o  (grant_vld_o),
    .burst_cnt_o  (burst_cnt_o)
  );

  function automatic int pick(input logic [N-1:0] r, input int p, input bit fp);
    for (int k = 0; k < N; k++) begin
      int j;
      j = fp ? k : (p + k) % N;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  // Reference model: owner as an integer, -1 meaning no grant.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_cnt   = 0;
    end else if (m_owner < 0) begin
      m_owner = pick(req_i, m_ptr, fixed_prio_i);
      m_cnt   = 0;
    end else begin
      int done;
      bit expired, rel;
      logic [N-1:0] r;
      done    = ack_i ? m_cnt + 1 : m_cnt;
      expired = ack_i && (done >= MB);
      rel     = !req_i[m_owner] || (ack_i && (!lock_i[m_owner] || expired));
      if (rel) begin
        r = req_i;
        if (expired) r[m_owner] = 1'b0;
        m_ptr   = (m_owner + 1) % N;
        m_cnt   = 0;
        m_owner = pick(r, m_ptr, fixed_prio_i);
      end else begin
        m_cnt = done;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      logic [N-1:0] eg;
      logic [1:0]   ei;
      logic         ev;
      eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      ei = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
      ev = (m_owner >= 0);
      checks++;
      if (grant_o !== eg || grant_idx_o !== ei || grant_vld_o !== ev ||
          burst_cnt_o !== 3'(m_cnt)) begin
        errors++;
        $display("FAIL model t=%0t got grant=%b idx=%0d vld=%b cnt=%0d want grant=%b idx=%0d vld=%b cnt=%0d",
                 $time, grant_o, grant_idx_o, grant_vld_o, burst_cnt_o, eg, ei, ev, m_cnt);
      end
    end
  end

  task automatic lit(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, exp);
    end
  endtask

  task automatic step(input logic [N-1:0] r, input logic [N-1:0] l,
                      input logic fp, input logic a);
    req_i = r; lock_i = l; fixed_prio_i = fp; ack_i = a;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    lit("reset_grant", int'(grant_o), 0);
    lit("reset_vld", int'(grant_vld_o), 0);
    lit("reset_cnt", int'(burst_cnt_o), 0);
    #1 rst = 1'b0;
    @(negedge clk);

    // First grant one cycle after request; handover proves pointer moved to 2
    step(4'b1010, 4'b0000, 1'b0, 1'b0);
    lit("rr_first_grant", int'(grant_o), 4'b0010);
    lit("rr_first_idx", int'(grant_idx_o), 1);
    step(4'b1010, 4'b0000, 1'b0, 1'b1);
    lit("rr_ptr_after_rel", int'(grant_idx_o), 3);
    step(4'b0000, 4'b0000, 1'b0, 1'b0);
    lit("abandon_idle", int'(grant_vld_o), 0);

    // Full rotation with acks every cycle, no bubbles
    step(4'b1111, 4'b0000, 1'b0, 1'b0);
    lit("rot_start", int'(grant_idx_o), 0);
    for (int i = 1; i <= 4; i++) begin
      step(4'b1111, 4'b0000, 1'b0, 1'b1);
      lit("rot_idx", int'(grant_idx_o), i % 4);
      lit("rot_vld", int'(grant_vld_o), 1);
    end
    step(4'b0000, 4'b0000, 1'b0, 1'b0);

    // Fixed priority locked burst runs to the limit then hands to 3
    step(4'b1100, 4'b0100, 1'b1, 1'b0);
    lit("fix_owner", int'(grant_idx_o), 2);
    for (int i = 1; i <= 3; i++) begin
      step(4'b1100, 4'b0100, 1'b1, 1'b1);
      lit("burst_cnt", int'(burst_cnt_o), i);
    end
    step(4'b1100, 4'b0100, 1'b1, 1'b1);
    lit("burst_handover", int'(grant_idx_o), 3);
    lit("burst_clear", int'(burst_cnt_o), 0);
    step(4'b0000, 4'b0000, 1'b1, 1'b0);

    // Owner 1 abandons mid-burst
    step(4'b0010, 4'b0010, 1'b0, 1'b0);
    step(4'b0010, 4'b0010, 1'b0, 1'b1);
    lit("pre_abandon_cnt", int'(burst_cnt_o), 1);
    step(4'b0000, 4'b0000, 1'b0, 1'b0);
    lit("abandon_vld", int'(grant_vld_o), 0);
    lit("abandon_cnt", int'(burst_cnt_o), 0);
    step(4'b0000, 4'b0000, 1'b0, 1'b1);
    lit("idle_ack_cnt", int'(burst_cnt_o), 0);

    // Asynchronous reset during owner 3's burst
    step(4'b1000, 4'b1000, 1'b0, 1'b0);
    step(4'b1000, 4'b1000, 1'b0, 1'b1);
    step(4'b1000, 4'b1000, 1'b0, 1'b1);
    lit("pre_rst_cnt", int'(burst_cnt_o), 2);
    lit("pre_rst_idx", int'(grant_idx_o), 3);
    #2 rst = 1'b1;
    #1;
    lit("async_rst_grant", int'(grant_o), 0);
    lit("async_rst_vld", int'(grant_vld_o), 0);
    lit("async_rst_cnt", int'(burst_cnt_o), 0);
    lit("async_rst_idx", int'(grant_idx_o), 0);
    req_i = '0; lock_i = '0; ack_i = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    step(4'b1000, 4'b0000, 1'b0, 1'b0);
    lit("post_rst_grant", int'(grant_o), 4'b1000);

    // Mode change mid-grant leaves owner alone, next pick is fixed
    step(4'b1001, 4'b0000, 1'b1, 1'b0);
    lit("mode_hold", int'(grant_idx_o), 3);
    step(4'b1001, 4'b0000, 1'b1, 1'b1);
    lit("mode_next", int'(grant_idx_o), 0);
    step(4'b0000, 4'b0000, 1'b1, 1'b0);

    // Unlocked release with a lone requester re-grants it without a gap
    step(4'b0100, 4'b0000, 1'b0, 1'b0);
    step(4'b0100, 4'b0000, 1'b0, 1'b1);
    lit("regrant_idx", int'(grant_idx_o), 2);
    lit("regrant_vld", int'(grant_vld_o), 1);
    step(4'b0000, 4'b0000, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
